program_counter_ras: RTL and testbench

Parametrised program counter with a return-address stack (RAS), the next generation of the processor's PC. It adds call/return, an optional PC-relative branch mode, a configurable reset vector and increment step, and stack status flags. It sits in the fetch stage and drives the instruction-memory address.

---
 rtl/program_counter_ras.sv | 113 +++++++++++
 tb/tb_program_counter_ras.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/program_counter_ras.sv
// Fetch-stage program counter with a circular return-address stack.
// Event priority on each edge: reset > ret > call > branch > enableJump > pcWrite > hold.
module program_counter_ras #(
  parameter int unsigned             ADDR_WIDTH      = 20,
  parameter int unsigned             RAS_DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0]   RESET_VECTOR    = '0,
  parameter int unsigned             STEP            = 1,
  parameter bit                      BRANCH_RELATIVE = 1'b0,
  localparam int unsigned            CntW            = $clog2(RAS_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pcWrite,
  input  logic                  branch,
  input  logic                  enableJump,
  input  logic                  call,
  input  logic                  ret,
  input  logic [ADDR_WIDTH-1:0] branchAddress,
  input  logic [ADDR_WIDTH-1:0] jumpAddress,
  output logic [ADDR_WIDTH-1:0] pcOut,
  output logic [CntW-1:0]       rasCount,
  output logic                  rasEmpty,
  output logic                  rasFull,
  output logic                  rasOverflow,
  output logic                  rasUnderflow
);

  localparam int unsigned           PtrW  = $clog2(RAS_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] StepA = ADDR_WIDTH'(STEP);
  localparam logic [CntW-1:0]       CntMax = CntW'(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PtrW-1:0]       top_q, top_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push;
  logic [ADDR_WIDTH-1:0] stack_q [RAS_DEPTH];

  logic [PtrW-1:0]       pop_idx;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic                  empty, full;

  // top_q addresses the next free slot; when full it is also the oldest entry.
  assign pop_idx  = top_q - PtrW'(1);
  assign ret_addr = pc_q + StepA;
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntMax);

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    top_d = top_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (ret) begin
      if (!empty) begin
        pc_d  = stack_q[pop_idx];
        cnt_d = cnt_q - CntW'(1);
        top_d = pop_idx;
      end else begin
        unf_d = 1'b1;
      end
    end else if (call) begin
      pc_d  = jumpAddress;
      push  = 1'b1;
      top_d = top_q + PtrW'(1);
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (branch) begin
      pc_d = BRANCH_RELATIVE ? (pc_q + StepA + branchAddress) : branchAddress;
    end else if (enableJump) begin
      pc_d = jumpAddress;
    end else if (pcWrite) begin
      pc_d = pc_q + StepA;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      stack_q[top_q] <= ret_addr;
    end
  end

  assign pcOut        = pc_q;
  assign rasCount     = cnt_q;
  assign rasEmpty     = empty;
  assign rasFull      = full;
  assign rasOverflow  = ovf_q;
  assign rasUnderflow = unf_q;

endmodule

// File: tb/tb_program_counter_ras.sv
// Bench for program_counter_ras: absolute- and relative-branch instances share stimulus and
// are compared every cycle against an ordered-list reference model.
module tb_program_counter_ras;

  localparam int AW = 20;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          reset, pcWrite, branch, enableJump, call, ret;
  logic [AW-1:0] branchAddress, jumpAddress;

  logic [AW-1:0] pc_o  [2];
  logic [2:0]    cnt_o [2];
  logic          emp_o [2];
  logic          ful_o [2];
  logic          ovf_o [2];
  logic          unf_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state; stk_m[k][0] is the oldest surviving return address.
  logic [AW-1:0] pc_m  [2];
  logic [AW-1:0] stk_m [2][D];
  int            n_m   [2];
  logic          ovf_m [2];
  logic          unf_m [2];

  always #5 clock = ~clock;

  program_counter_ras #(
    .ADDR_WIDTH(AW), .RAS_DEPTH(D), .RESET_VECTOR('0), .STEP(1), .BRANCH_RELATIVE(1'b0)
  ) u_abs (
    .clock(clock), .reset(reset), .pcWrite(pcWrite), .branch(branch),
    .enableJump(enableJump), .call(call), .ret(ret),
    .branchAddress(branchAddress), .jumpAddress(jumpAddress),
    .pcOut(pc_o[0]), .rasCount(cnt_o[0]), .rasEmpty(emp_o[0]), .rasFull(ful_o[0]),
    .rasOverflow(ovf_o[0]), .rasUnderflow(unf_o[0])
  );

  program_counter_ras #(
    .ADDR_WIDTH(AW), .RAS_DEPTH(D), .RESET_VECTOR('0), .STEP(1), .BRANCH_RELATIVE(1'b1)
  ) u_rel (
    .clock(clock), .reset(reset), .pcWrite(pcWrite), .branch(branch),
    .enableJump(enableJump), .call(call), .ret(ret),
    .branchAddress(branchAddress), .jumpAddress(jumpAddress),
    .pcOut(pc_o[1]), .rasCount(cnt_o[1]), .rasEmpty(emp_o[1]), .rasFull(ful_o[1]),
    .rasOverflow(ovf_o[1]), .rasUnderflow(unf_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        pc_m[k] = '0; n_m[k] = 0; ovf_m[k] = 1'b0; unf_m[k] = 1'b0;
      end else if (ret) begin
        if (n_m[k] > 0) begin
          n_m[k]--;
          pc_m[k] = stk_m[k][n_m[k]];
        end else begin
          unf_m[k] = 1'b1;
        end
      end else if (call) begin
        if (n_m[k] == D) begin
          for (int i = 0; i < D - 1; i++) stk_m[k][i] = stk_m[k][i+1];
          n_m[k]   = D - 1;
          ovf_m[k] = 1'b1;
        end
        stk_m[k][n_m[k]] = pc_m[k] + 20'd1;
        n_m[k]++;
        pc_m[k] = jumpAddress;
      end else if (branch) begin
        pc_m[k] = (k == 1) ? pc_m[k] + 20'd1 + branchAddress : branchAddress;
      end else if (enableJump) begin
        pc_m[k] = jumpAddress;
      end else if (pcWrite) begin
        pc_m[k] = pc_m[k] + 20'd1;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("pc[%0d]", k),    32'(pc_o[k]),  32'(pc_m[k]));
      check($sformatf("count[%0d]", k), 32'(cnt_o[k]), 32'(n_m[k]));
      check($sformatf("empty[%0d]", k), 32'(emp_o[k]), 32'(n_m[k] == 0));
      check($sformatf("full[%0d]", k),  32'(ful_o[k]), 32'(n_m[k] == D));
      check($sformatf("ovf[%0d]", k),   32'(ovf_o[k]), 32'(ovf_m[k]));
      check($sformatf("unf[%0d]", k),   32'(unf_o[k]), 32'(unf_m[k]));
    end
  endtask

  // Apply one cycle of inputs, advance the edge, then compare 1 time unit later.
  task automatic drive(input logic r, input logic pw, input logic br, input logic j,
                       input logic c, input logic rt, input logic [AW-1:0] ba,
                       input logic [AW-1:0] ja);
    reset = r; pcWrite = pw; branch = br; enableJump = j; call = c; ret = rt;
    branchAddress = ba; jumpAddress = ja;
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_jump(input logic [AW-1:0] a);
    drive(0, 0, 0, 1, 0, 0, '0, a);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      pc_m[k] = '0; n_m[k] = 0; ovf_m[k] = 1'b0; unf_m[k] = 1'b0;
    end
    #2;

    // Reset then sequential advance.
    drive(1, 0, 0, 0, 0, 0, '0, '0);
    check("rst_pc", 32'(pc_o[0]), 32'h0);
    check("rst_empty", 32'(emp_o[0]), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 0, 0, 0, 0, '0, '0);
      check("adv_pc", 32'(pc_o[0]), 32'(i));
    end

    // Priority: branch beats enableJump and pcWrite.
    idle_jump(20'h00010);
    drive(0, 1, 1, 1, 0, 0, 20'h00100, 20'h00200);
    check("prio_abs", 32'(pc_o[0]), 32'h00100);
    check("prio_rel", 32'(pc_o[1]), 32'h00111);

    // Nested call/return.
    idle_jump(20'h00005);
    drive(0, 0, 0, 0, 1, 0, '0, 20'h00040);
    check("call1_pc", 32'(pc_o[0]), 32'h00040);
    drive(0, 0, 0, 0, 1, 0, '0, 20'h00080);
    check("call2_cnt", 32'(cnt_o[0]), 32'h2);
    drive(0, 0, 0, 0, 0, 1, '0, '0);
    check("ret1_pc", 32'(pc_o[0]), 32'h00041);
    drive(0, 0, 0, 0, 0, 1, '0, '0);
    check("ret2_pc", 32'(pc_o[0]), 32'h00006);
    check("ret2_cnt", 32'(cnt_o[0]), 32'h0);

    // Overflow after five calls, then four pops and an underflow.
    drive(1, 0, 0, 0, 0, 0, '0, '0);
    for (int i = 1; i <= 5; i++) drive(0, 0, 0, 0, 1, 0, '0, 20'(i * 'h100));
    check("ovf_flag", 32'(ovf_o[0]), 32'h1);
    check("ovf_cnt", 32'(cnt_o[0]), 32'h4);
    for (int i = 4; i >= 1; i--) begin
      drive(0, 0, 0, 0, 0, 1, '0, '0);
      check("ovf_pop", 32'(pc_o[0]), 32'(i * 'h100 + 1));
    end
    drive(0, 0, 0, 0, 0, 1, '0, '0);
    check("unf_hold", 32'(pc_o[0]), 32'h00101);
    check("unf_flag", 32'(unf_o[0]), 32'h1);

    // Relative negative branch and PC wrap.
    idle_jump(20'h00010);
    drive(0, 0, 1, 0, 0, 0, 20'hFFFF0, '0);
    check("rel_neg", 32'(pc_o[1]), 32'h00001);
    idle_jump(20'hFFFFF);
    drive(0, 1, 0, 0, 0, 0, '0, '0);
    check("wrap", 32'(pc_o[0]), 32'h00000);

    // call+ret together pops only; reset during a call clears everything.
    drive(1, 0, 0, 0, 0, 0, '0, '0);
    drive(0, 0, 0, 0, 1, 0, '0, 20'h00050);
    drive(0, 0, 0, 0, 1, 1, '0, 20'h00070);
    check("cr_pc", 32'(pc_o[0]), 32'h00001);
    check("cr_cnt", 32'(cnt_o[0]), 32'h0);
    drive(0, 0, 0, 0, 0, 1, '0, '0);
    drive(0, 0, 0, 0, 1, 0, '0, 20'h00090);
    drive(1, 0, 0, 0, 1, 0, '0, 20'h000A0);
    check("rst_call_pc", 32'(pc_o[0]), 32'h0);
    check("rst_call_unf", 32'(unf_o[0]), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom % 64) == 0, ($urandom % 2) == 0, ($urandom % 5) == 0,
            ($urandom % 5) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
            20'($urandom), 20'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
